// File: rtl/pong_pkg.sv
// Shared definitions for the pong game: FSM state encoding, direction
// encoding, coordinate type and the default screen/paddle geometry that the
// draw stages also rely on.
package pong_pkg;

  // Game FSM states; the encoding is visible on state_out.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    MISS = 2'd2,
    OVER = 2'd3
  } state_e;

  // One bit per axis, set means moving towards larger coordinates.
  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

  // Internal coordinates are 12-bit unsigned; only the low 11 bits leave the block.
  localparam int COORD_W = 12;
  typedef logic [COORD_W-1:0] coord_t;

  // Default geometry shared with the rect/char drawing stages.
  localparam int PONG_H_RES       = 1024;
  localparam int PONG_V_RES       = 768;
  localparam int PONG_BALL_SIZE   = 16;
  localparam int PONG_PADDLE_X    = 32;
  localparam int PONG_PADDLE_W    = 8;
  localparam int PONG_PADDLE_H    = 96;
  localparam int PONG_SPEED       = 4;
  localparam int PONG_LIVES       = 3;
  localparam int PONG_MISS_FRAMES = 60;

  // Saturate a coordinate at an upper limit.
  function automatic coord_t clamp_coord(input coord_t value, input coord_t limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/bcd_inc2.sv
// Two-digit packed BCD incrementer, purely combinational; 99 wraps to 00.
// Also used by the seven-segment score path.
module bcd_inc2 (
  input  logic [7:0] bcd_in,
  output logic [7:0] bcd_out
);

  // Bump the ones digit, carrying into the tens digit on 9.
  always_comb begin
    bcd_out = bcd_in;
    if (bcd_in[3:0] >= 4'd9) begin
      bcd_out[3:0] = 4'd0;
      if (bcd_in[7:4] >= 4'd9) begin
        bcd_out[7:4] = 4'd0;
      end else begin
        bcd_out[7:4] = bcd_in[7:4] + 4'd1;
      end
    end else begin
      bcd_out[3:0] = bcd_in[3:0] + 4'd1;
    end
  end

endmodule

// File: rtl/pong_ball_ctl.sv
// Per-frame pong physics: moves the ball once per vblank, bounces it off the
// walls and the paddle, keeps the BCD score and the remaining lives, and runs
// the IDLE/PLAY/MISS/OVER game flow. The paddle follows the mouse every clock.
module pong_ball_ctl
  import pong_pkg::*;
#(
  parameter int H_RES       = PONG_H_RES,
  parameter int V_RES       = PONG_V_RES,
  parameter int BALL_SIZE   = PONG_BALL_SIZE,
  parameter int PADDLE_X    = PONG_PADDLE_X,
  parameter int PADDLE_W    = PONG_PADDLE_W,
  parameter int PADDLE_H    = PONG_PADDLE_H,
  parameter int SPEED       = PONG_SPEED,
  parameter int LIVES       = PONG_LIVES,
  parameter int MISS_FRAMES = PONG_MISS_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic [11:0] ypos,
  input  logic        button,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [10:0] paddle_y,
  output logic [7:0]  score,
  output logic [3:0]  lives,
  output logic [1:0]  state_out
);

  localparam int MISS_W = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;

  localparam coord_t CENTRE_X   = coord_t'((H_RES - BALL_SIZE) / 2);
  localparam coord_t CENTRE_Y   = coord_t'((V_RES - BALL_SIZE) / 2);
  localparam coord_t STEP       = coord_t'(SPEED);
  localparam coord_t BALL_SZ    = coord_t'(BALL_SIZE);
  localparam coord_t SCREEN_W   = coord_t'(H_RES);
  localparam coord_t SCREEN_H   = coord_t'(V_RES);
  localparam coord_t X_RIGHT    = coord_t'(H_RES - BALL_SIZE);
  localparam coord_t Y_BOTTOM   = coord_t'(V_RES - BALL_SIZE);
  localparam coord_t PAD_LEFT   = coord_t'(PADDLE_X);
  localparam coord_t PAD_FACE   = coord_t'(PADDLE_X + PADDLE_W);
  localparam coord_t PAD_REACH  = coord_t'(PADDLE_X + PADDLE_W + SPEED);
  localparam coord_t PAD_HEIGHT = coord_t'(PADDLE_H);
  localparam coord_t PAD_MAX    = coord_t'(V_RES - PADDLE_H);

  localparam logic [3:0]        LIVES_INIT = 4'(LIVES);
  localparam logic [MISS_W-1:0] MISS_LAST  = MISS_W'(MISS_FRAMES - 1);
  localparam logic [MISS_W-1:0] MISS_ONE   = MISS_W'(1);

  state_e            state_q, state_d;
  coord_t            ball_x_q, ball_x_d;
  coord_t            ball_y_q, ball_y_d;
  coord_t            paddle_y_q, paddle_y_d;
  logic              dx_q, dx_d;
  logic              dy_q, dy_d;
  logic [7:0]        score_q, score_d;
  logic [3:0]        lives_q, lives_d;
  logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
  logic              vblnk_d_q, vblnk_d_d;
  logic              button_d_q, button_d_d;
  logic              tick_q, tick_d;
  logic              pend_q, pend_d;

  logic              frame_tick;
  logic              serve;
  logic              paddle_hit;
  logic [7:0]        score_inc;
  logic              unused_msb;

  assign frame_tick = vblnk_in & ~vblnk_d_q;
  assign serve      = button & ~button_d_q;

  bcd_inc2 u_score_inc (
    .bcd_in  (score_q),
    .bcd_out (score_inc)
  );

  // Edge detectors, registered frame tick and the paddle clamp all run every clock.
  always_comb begin
    vblnk_d_d  = vblnk_in;
    button_d_d = button;
    tick_d     = frame_tick;
    paddle_y_d = clamp_coord(ypos, PAD_MAX);
  end

  // Paddle contact uses the ball position from before this frame's move.
  always_comb begin
    paddle_hit = (dx_q == DIR_NEG) && (ball_x_q <= PAD_REACH) && (ball_x_q >= PAD_LEFT) &&
                 (ball_y_q + BALL_SZ > paddle_y_q) && (ball_y_q < paddle_y_q + PAD_HEIGHT);
  end

  // Game FSM and per-frame ball physics; a serve is held until the next frame tick.
  always_comb begin
    state_d    = state_q;
    ball_x_d   = ball_x_q;
    ball_y_d   = ball_y_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    score_d    = score_q;
    lives_d    = lives_q;
    miss_cnt_d = miss_cnt_q;
    pend_d     = pend_q;

    if (serve && ((state_q == IDLE) || (state_q == OVER))) begin
      pend_d = 1'b1;
    end

    if (tick_q) begin
      case (state_q)
        IDLE: begin
          ball_x_d = CENTRE_X;
          ball_y_d = CENTRE_Y;
          if (pend_q) begin
            pend_d  = 1'b0;
            dx_d    = DIR_NEG;
            dy_d    = DIR_POS;
            state_d = PLAY;
          end
        end
        PLAY: begin
          if ((dy_q == DIR_NEG) && (ball_y_q <= STEP)) begin
            ball_y_d = '0;
            dy_d     = DIR_POS;
          end else if ((dy_q == DIR_POS) && (ball_y_q + BALL_SZ + STEP >= SCREEN_H)) begin
            ball_y_d = Y_BOTTOM;
            dy_d     = DIR_NEG;
          end else if (dy_q == DIR_POS) begin
            ball_y_d = ball_y_q + STEP;
          end else begin
            ball_y_d = ball_y_q - STEP;
          end

          if ((dx_q == DIR_POS) && (ball_x_q + BALL_SZ + STEP >= SCREEN_W)) begin
            ball_x_d = X_RIGHT;
            dx_d     = DIR_NEG;
          end else if (paddle_hit) begin
            ball_x_d = PAD_FACE;
            dx_d     = DIR_POS;
            score_d  = score_inc;
          end else if ((dx_q == DIR_NEG) && (ball_x_q <= STEP)) begin
            ball_x_d   = '0;
            lives_d    = lives_q - 4'd1;
            miss_cnt_d = '0;
            state_d    = MISS;
          end else if (dx_q == DIR_POS) begin
            ball_x_d = ball_x_q + STEP;
          end else begin
            ball_x_d = ball_x_q - STEP;
          end
        end
        MISS: begin
          if (miss_cnt_q == MISS_LAST) begin
            ball_x_d = CENTRE_X;
            ball_y_d = CENTRE_Y;
            if (lives_q != 4'd0) begin
              dx_d    = DIR_NEG;
              dy_d    = DIR_POS;
              state_d = PLAY;
            end else begin
              state_d = OVER;
            end
          end else begin
            miss_cnt_d = miss_cnt_q + MISS_ONE;
          end
        end
        OVER: begin
          ball_x_d = CENTRE_X;
          ball_y_d = CENTRE_Y;
          if (pend_q) begin
            pend_d  = 1'b0;
            score_d = 8'h00;
            lives_d = LIVES_INIT;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State register; reset overrides everything, including a frame update in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      ball_x_q   <= CENTRE_X;
      ball_y_q   <= CENTRE_Y;
      paddle_y_q <= '0;
      dx_q       <= DIR_POS;
      dy_q       <= DIR_POS;
      score_q    <= 8'h00;
      lives_q    <= LIVES_INIT;
      miss_cnt_q <= '0;
      vblnk_d_q  <= 1'b0;
      button_d_q <= 1'b0;
      tick_q     <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ball_x_q   <= ball_x_d;
      ball_y_q   <= ball_y_d;
      paddle_y_q <= paddle_y_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      miss_cnt_q <= miss_cnt_d;
      vblnk_d_q  <= vblnk_d_d;
      button_d_q <= button_d_d;
      tick_q     <= tick_d;
      pend_q     <= pend_d;
    end
  end

  assign ball_x     = ball_x_q[10:0];
  assign ball_y     = ball_y_q[10:0];
  assign paddle_y   = paddle_y_q[10:0];
  assign score      = score_q;
  assign lives      = lives_q;
  assign state_out  = state_q;
  assign unused_msb = ^{ball_x_q[11], ball_y_q[11], paddle_y_q[11]};

endmodule

// File: tb/tb_pong_ball_ctl.sv
// Testbench for pong_ball_ctl: drives frames and serves, and compares every
// output against a per-frame behavioural model of the game rules.
module tb_pong_ball_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vblnk_in = 1'b0;
  logic [11:0] ypos = 12'd0;
  logic        button = 1'b0;
  logic [10:0] ball_x, ball_y, paddle_y;
  logic [7:0]  score;
  logic [3:0]  lives;
  logic [1:0]  state_out;
  logic [7:0]  bcd_a = 8'h00;
  logic [7:0]  bcd_y;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: 0 idle, 1 play, 2 miss, 3 over; directions are +1/-1.
  int m_state, m_x, m_y, m_dx, m_dy, m_score, m_lives, m_miss, m_pad;
  bit m_pend;
  int n_hits = 0, n_walls = 0, n_misses = 0;

  pong_ball_ctl dut (
    .clk       (clk),
    .rst       (rst),
    .vblnk_in  (vblnk_in),
    .ypos      (ypos),
    .button    (button),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .paddle_y  (paddle_y),
    .score     (score),
    .lives     (lives),
    .state_out (state_out)
  );

  bcd_inc2 u_bcd (
    .bcd_in  (bcd_a),
    .bcd_out (bcd_y)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model_reset();
    m_state = 0; m_x = 504; m_y = 376; m_dx = 1; m_dy = 1;
    m_score = 0; m_lives = 3; m_miss = 0; m_pend = 0; m_pad = 0;
  endtask

  task automatic set_ypos(input int v);
    ypos  = 12'(v);
    m_pad = (v > 672) ? 672 : v;
  endtask

  // One frame of game rules, applied at the frame tick.
  task automatic model_frame(input bit press);
    bit hit;
    if (press && (m_state == 0 || m_state == 3)) m_pend = 1;
    case (m_state)
      0: if (m_pend) begin
        m_pend = 0; m_state = 1; m_dx = -1; m_dy = 1;
      end
      1: begin
        hit = (m_dx < 0) && (m_x <= 44) && (m_x >= 32) &&
              (m_y + 16 > m_pad) && (m_y < m_pad + 96);
        if (m_dy < 0 && m_y <= 4) begin
          m_y = 0; m_dy = 1; n_walls++;
        end else if (m_dy > 0 && m_y + 20 >= 768) begin
          m_y = 752; m_dy = -1; n_walls++;
        end else begin
          m_y = m_y + 4 * m_dy;
        end
        if (m_dx > 0 && m_x + 20 >= 1024) begin
          m_x = 1008; m_dx = -1; n_walls++;
        end else if (hit) begin
          m_x = 40; m_dx = 1; m_score = (m_score + 1) % 100; n_hits++;
        end else if (m_dx < 0 && m_x <= 4) begin
          m_x = 0; m_lives--; m_miss = 0; m_state = 2; n_misses++;
        end else begin
          m_x = m_x + 4 * m_dx;
        end
      end
      2: begin
        if (m_miss == 59) begin
          m_x = 504; m_y = 376;
          if (m_lives != 0) begin
            m_dx = -1; m_dy = 1; m_state = 1;
          end else begin
            m_state = 3;
          end
        end else begin
          m_miss++;
        end
      end
      default: if (m_pend) begin
        m_pend = 0; m_score = 0; m_lives = 3; m_state = 0;
      end
    endcase
  endtask

  // Drive one vblank pulse (optionally with a button press) and advance the model.
  task automatic run_frame(input bit press);
    @(negedge clk);
    vblnk_in = 1'b1;
    if (press) button = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vblnk_in = 1'b0;
    button   = 1'b0;
    @(negedge clk);
    model_frame(press);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_ypos(0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    n_checks++; if (ball_x !== 11'd504) begin n_fail++; $display("[TB] FAIL reset_ball_x: got %0d expected 504", ball_x); end
    n_checks++; if (ball_y !== 11'd376) begin n_fail++; $display("[TB] FAIL reset_ball_y: got %0d expected 376", ball_y); end
    n_checks++; if (score !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_score: got %h expected 00", score); end
    n_checks++; if (lives !== 4'd3) begin n_fail++; $display("[TB] FAIL reset_lives: got %0d expected 3", lives); end
    n_checks++; if (state_out !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_state: got %0d expected 0", state_out); end
    n_checks++; if (paddle_y !== 11'd0) begin n_fail++; $display("[TB] FAIL reset_paddle: got %0d expected 0", paddle_y); end
    for (int i = 0; i < 5; i++) begin
      run_frame(1'b0);
      n_checks++; if (ball_x !== 11'd504 || ball_y !== 11'd376) begin n_fail++; $display("[TB] FAIL idle_hold: got %0d,%0d expected 504,376", ball_x, ball_y); end
      n_checks++; if (state_out !== 2'd0) begin n_fail++; $display("[TB] FAIL idle_state: got %0d expected 0", state_out); end
    end
  endtask

  task automatic test_bcd();
    logic [7:0] exp_v;
    for (int i = 0; i < 100; i++) begin
      bcd_a = to_bcd(i);
      exp_v = to_bcd((i + 1) % 100);
      #1;
      n_checks++; if (bcd_y !== exp_v) begin n_fail++; $display("[TB] FAIL bcd_inc in=%h: got %h expected %h", bcd_a, bcd_y, exp_v); end
    end
  endtask

  task automatic test_serve_move();
    set_ypos(int'($urandom_range(0, 4095)));
    run_frame(1'b1);
    n_checks++; if (state_out !== 2'd1) begin n_fail++; $display("[TB] FAIL serve_state: got %0d expected 1", state_out); end
    n_checks++; if (ball_x !== 11'd504 || ball_y !== 11'd376) begin n_fail++; $display("[TB] FAIL serve_no_move: got %0d,%0d expected 504,376", ball_x, ball_y); end
    n_checks++; if (paddle_y !== 11'(m_pad)) begin n_fail++; $display("[TB] FAIL serve_paddle: got %0d expected %0d", paddle_y, m_pad); end
    @(negedge clk);
    vblnk_in = 1'b1;
    @(negedge clk);
    n_checks++; if (ball_x !== 11'd504 || ball_y !== 11'd376) begin n_fail++; $display("[TB] FAIL latency_early: got %0d,%0d expected 504,376", ball_x, ball_y); end
    @(negedge clk);
    n_checks++; if (ball_x !== 11'd500 || ball_y !== 11'd380) begin n_fail++; $display("[TB] FAIL first_move: got %0d,%0d expected 500,380", ball_x, ball_y); end
    vblnk_in = 1'b0;
    @(negedge clk);
    model_frame(1'b0);
  endtask

  task automatic test_play();
    int t;
    for (int f = 0; f < 4000 && m_state != 3; f++) begin
      if (m_score < 2) begin
        t = m_y - int'($urandom_range(10, 70));
        set_ypos((t < 0) ? 0 : t);
      end else if (m_y < 300) begin
        set_ypos(int'($urandom_range(700, 4095)));
      end else begin
        set_ypos(int'($urandom_range(0, 50)));
      end
      run_frame($urandom_range(0, 7) == 0);
      n_checks++; if (ball_x !== 11'(m_x)) begin n_fail++; $display("[TB] FAIL play_ball_x f=%0d: got %0d expected %0d", f, ball_x, m_x); end
      n_checks++; if (ball_y !== 11'(m_y)) begin n_fail++; $display("[TB] FAIL play_ball_y f=%0d: got %0d expected %0d", f, ball_y, m_y); end
      n_checks++; if (score !== to_bcd(m_score)) begin n_fail++; $display("[TB] FAIL play_score f=%0d: got %h expected %h", f, score, to_bcd(m_score)); end
      n_checks++; if (lives !== 4'(m_lives)) begin n_fail++; $display("[TB] FAIL play_lives f=%0d: got %0d expected %0d", f, lives, m_lives); end
      n_checks++; if (state_out !== 2'(m_state)) begin n_fail++; $display("[TB] FAIL play_state f=%0d: got %0d expected %0d", f, state_out, m_state); end
      n_checks++; if (paddle_y !== 11'(m_pad)) begin n_fail++; $display("[TB] FAIL play_paddle f=%0d: got %0d expected %0d", f, paddle_y, m_pad); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    n_checks++; if (state_out !== 2'd3) begin n_fail++; $display("[TB] FAIL game_over_reached: got %0d expected 3", state_out); end
    $display("[TB] play done: hits=%0d walls=%0d misses=%0d", n_hits, n_walls, n_misses);
  endtask

  task automatic test_over_serve();
    n_checks++; if (ball_x !== 11'd504 || ball_y !== 11'd376) begin n_fail++; $display("[TB] FAIL over_centre: got %0d,%0d expected 504,376", ball_x, ball_y); end
    n_checks++; if (lives !== 4'd0) begin n_fail++; $display("[TB] FAIL over_lives: got %0d expected 0", lives); end
    run_frame(1'b0);
    n_checks++; if (state_out !== 2'd3) begin n_fail++; $display("[TB] FAIL over_hold: got %0d expected 3", state_out); end
    run_frame(1'b1);
    n_checks++; if (state_out !== 2'd0) begin n_fail++; $display("[TB] FAIL over_serve_state: got %0d expected 0", state_out); end
    n_checks++; if (lives !== 4'd3) begin n_fail++; $display("[TB] FAIL over_serve_lives: got %0d expected 3", lives); end
    n_checks++; if (score !== 8'h00) begin n_fail++; $display("[TB] FAIL over_serve_score: got %h expected 00", score); end
  endtask

  task automatic test_clamp_reset();
    set_ypos(int'($urandom_range(0, 600)));
    run_frame(1'b1);
    for (int i = 0; i < 3; i++) run_frame(1'b0);
    n_checks++; if (state_out !== 2'(m_state) || ball_x !== 11'(m_x) || ball_y !== 11'(m_y)) begin
      n_fail++; $display("[TB] FAIL pre_reset_play: got s=%0d x=%0d y=%0d expected s=%0d x=%0d y=%0d", state_out, ball_x, ball_y, m_state, m_x, m_y);
    end
    @(negedge clk);
    ypos = 12'd4000;
    @(negedge clk);
    n_checks++; if (paddle_y !== 11'd672) begin n_fail++; $display("[TB] FAIL paddle_clamp: got %0d expected 672", paddle_y); end
    rst = 1'b0;
    vblnk_in = 1'b1;
    @(negedge clk);
    n_checks++; if (ball_x !== 11'd504 || ball_y !== 11'd376) begin n_fail++; $display("[TB] FAIL midplay_reset_ball: got %0d,%0d expected 504,376", ball_x, ball_y); end
    n_checks++; if (state_out !== 2'd0 || lives !== 4'd3 || score !== 8'h00) begin
      n_fail++; $display("[TB] FAIL midplay_reset_regs: got s=%0d l=%0d sc=%h expected s=0 l=3 sc=00", state_out, lives, score);
    end
    n_checks++; if (paddle_y !== 11'd0) begin n_fail++; $display("[TB] FAIL midplay_reset_paddle: got %0d expected 0", paddle_y); end
    @(negedge clk);
    vblnk_in = 1'b0;
    rst = 1'b1;
    model_reset();
    set_ypos(100);
    run_frame(1'b0);
    n_checks++; if (state_out !== 2'd0 || ball_x !== 11'd504 || paddle_y !== 11'd100) begin
      n_fail++; $display("[TB] FAIL post_reset_idle: got s=%0d x=%0d p=%0d expected s=0 x=504 p=100", state_out, ball_x, paddle_y);
    end
  endtask

  initial begin
    $display("[TB] starting pong_ball_ctl bench");
    test_reset();
    test_bcd();
    test_serve_move();
    test_play();
    test_over_serve();
    test_clamp_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_ball_ctl.md
Name: pong_ball_ctl

Overview:
Per-frame game-physics engine for the pong design: advances ball position, resolves wall and paddle collisions, tracks score and lives.
Sits between the mouse-delay stage and the top-level draw/control block, in the pclk (65 MHz) domain. Consumes delayed mouse ypos, the serve button and vblnk from the VGA timing stage. Produces registered ball/paddle coordinates and score for the rect/char drawing stages.

Parameters:
H_RES, 1024, visible width in pixels
V_RES, 768, visible height in pixels
BALL_SIZE, 16, ball square edge in pixels
PADDLE_X, 32, paddle left edge x
PADDLE_W, 8, paddle width
PADDLE_H, 96, paddle height
SPEED, 4, pixels per frame on each axis (1..BALL_SIZE-1)
LIVES, 3, lives at game start (1..15)
MISS_FRAMES, 60, frames ball is held after a miss

Ports:
clk  input  1  pixel clock (65 MHz)
rst  input  1  synchronous active-low reset
vblnk_in  input  1  vertical blank from VGA timing; rising edge = frame tick
ypos  input  12  delayed mouse y position
button  input  1  serve/start, already synchronised to clk
ball_x  output  11  ball left edge
ball_y  output  11  ball top edge
paddle_y  output  11  clamped paddle top edge
score  output  8  hit count, two BCD digits
lives  output  4  remaining lives
state_out  output  2  current FSM state (encoding from package)

Behaviour:
- Reset (rst==0 at a clk edge):
  - ball_x=(H_RES-BALL_SIZE)/2, ball_y=(V_RES-BALL_SIZE)/2.
  - paddle_y=0, score=8'h00, lives=LIVES, direction dx=+1, dy=+1.
  - miss counter=0, state=IDLE, edge-detect registers=0.
  - Reset wins over every other event, including mid-frame update.
- Edge detection: vblnk_d and button_d are registered each clk.
  - frame_tick = vblnk_in & ~vblnk_d.
  - serve = button & ~button_d.
- Paddle: every clk, paddle_y <= min(ypos, V_RES-PADDLE_H), truncated to 11 bits. Latency 1 clk, independent of state.
- All other outputs update only on the clk after a frame_tick; stable for the rest of the frame. Latency: vblnk_in rise at edge N gives new ball_x/ball_y after edge N+2.
- FSM states IDLE, PLAY, MISS, OVER:
  - IDLE: ball held at centre. On serve: -> PLAY; dx=-1, dy=+1.
  - PLAY, each frame_tick, evaluated in this order:
    - Vertical: if dy<0 and ball_y<=SPEED, then ball_y=0 and dy=+1.
    - Else if dy>0 and ball_y+BALL_SIZE+SPEED>=V_RES, then ball_y=V_RES-BALL_SIZE and dy=-1.
    - Else ball_y+=dy*SPEED.
    - Right: if dx>0 and ball_x+BALL_SIZE+SPEED>=H_RES, then ball_x=H_RES-BALL_SIZE and dx=-1.
    - Paddle: if dx<0 and ball_x<=PADDLE_X+PADDLE_W+SPEED and ball_x>=PADDLE_X, test overlap: ball_y+BALL_SIZE>paddle_y and ball_y<paddle_y+PADDLE_H. Use the pre-update ball_y.
    - On overlap: ball_x=PADDLE_X+PADDLE_W, dx=+1, score BCD +1 (99 wraps to 00).
    - If no overlap, the ball keeps moving left.
    - Miss: if dx<0 and ball_x<=SPEED, then ball_x=0, lives-=1, miss counter=0, -> MISS.
    - Vertical and horizontal resolve in the same frame (corner hit legal).
  - MISS: ball frozen; counter increments per frame_tick.
    - When counter==MISS_FRAMES-1 and lives!=0: ball recentred, dx=-1, dy=+1, -> PLAY.
    - When counter==MISS_FRAMES-1 and lives==0: -> OVER.
  - OVER: ball at centre. On serve: score=0, lives=LIVES, -> IDLE.
- serve is ignored in PLAY and MISS. A serve coinciding with frame_tick in IDLE takes the transition; no movement that frame.
- Arithmetic: internal coordinates are 12-bit unsigned; comparisons are done before subtraction so no underflow. Outputs are the low 11 bits.

Decomposition:
- Package pong_pkg holds:
  - state enum (IDLE=0, PLAY=1, MISS=2, OVER=3).
  - direction encoding (1 bit per axis, 1=positive).
  - screen and paddle geometry constants shared with the draw stages.
- Sub-module bcd_inc2: 8-bit two-digit BCD incrementer with wrap, combinational. Reused by the seven-segment score path.

Test Plan:
- Reset: hold rst=0 for 3 clks, release -> ball_x=504, ball_y=376, score=00, lives=3, state_out=0. Pulse vblnk_in 5 times -> no ball movement.
- Serve and move: press button in IDLE, then one vblnk_in rise -> state_out=1. After next tick: ball_x=500, ball_y=380, update exactly 2 clks after the vblnk_in rise.
- Wall bounce: force PLAY with ball_y=750, dy=+1, then one tick -> ball_y=752, dy flips. Next tick -> ball_y=748.
- Paddle hit: ypos=300, ball_x=42, ball_y=350, dx=-1, then tick -> ball_x=40, dx=+1, score 00->01. Also preload score=8'h99, hit -> score=8'h00.
- Miss and game over: ypos=0, ball at y=600 moving left. Ball reaches x=0 -> lives 3->2, state MISS. After 60 ticks -> PLAY, ball centred. Repeat until lives=0 -> OVER. Serve -> IDLE, lives=3, score=00.
- Paddle clamp plus mid-play reset: ypos=12'd4000 -> paddle_y=672 one clk later. Assert rst=0 during PLAY -> all outputs at reset values on the next clk.
